// File: rtl/gen1_tx_os_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gen1_tx_os_scheduler_pkg
// Purpose  : Shared symbols, state encoding and beat-formatting helpers for
//            the Gen1/Gen2 transmit ordered-set scheduler.
// Contents : c_COM / c_SKP / c_IDL_DATA symbol constants, tx_sched_state_e,
//            tx_beat_t, bytes_per_cycle(), skp_os_beat(), mask_beat().
// Revision : 1.0 - initial release
// ============================================================================
package gen1_tx_os_scheduler_pkg;

    localparam logic [7:0] c_COM      = 8'hBC;
    localparam logic [7:0] c_SKP      = 8'h1C;
    localparam logic [7:0] c_IDL_DATA = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PKT    = 2'd1,
        SKP_OS = 2'd2
    } tx_sched_state_e;

    typedef struct packed {
        logic [3:0]  k;
        logic [31:0] data;
    } tx_beat_t;

    // PIPE width 8/16/32 maps to 1/2/4 bytes per cycle (width >> 3).
    function automatic logic [2:0] bytes_per_cycle(input logic [5:0] pipe_width);
        return pipe_width[5:3];
    endfunction

    // One beat of the COM + 3xSKP ordered set. Symbol index within the set is
    // idx*bpc + lane; symbol 0 is COM, the rest SKP. Unused lanes stay zero.
    function automatic tx_beat_t skp_os_beat(input logic [2:0] bpc, input logic [1:0] idx);
        tx_beat_t beat;
        int       sym;
        beat = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < int'(bpc)) begin
                sym                = int'(idx) * int'(bpc) + j;
                beat.data[8*j +: 8] = (sym == 0) ? c_COM : c_SKP;
                beat.k[j]          = 1'b1;
            end
        end
        return beat;
    endfunction

    // Pass only the lanes that exist at the current PIPE width.
    function automatic tx_beat_t mask_beat(input logic [2:0] bpc, input logic [31:0] data,
                                           input logic [3:0] k);
        tx_beat_t beat;
        beat = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < int'(bpc)) begin
                beat.data[8*j +: 8] = data[8*j +: 8];
                beat.k[j]          = k[j];
            end
        end
        return beat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gen1_tx_os_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : gen1_tx_os_scheduler_if
// Purpose  : Upstream packet-beat handshake into the TX ordered-set scheduler.
// Signals  : tx_data[31:0] (byte0 in [7:0]), tx_data_k[3:0], tx_valid,
//            tx_last, tx_ready (beat accepted on tx_valid && tx_ready).
// Modports : master - link layer source, slave - scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface gen1_tx_os_scheduler_if;
    logic [31:0] tx_data;
    logic [3:0]  tx_data_k;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;

    modport master (output tx_data, tx_data_k, tx_valid, tx_last, input tx_ready);
    modport slave  (input tx_data, tx_data_k, tx_valid, tx_last, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/gen1_tx_os_scheduler_skp_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : gen1_tx_os_scheduler_skp_interval_timer
// Purpose  : SKP interval accumulator with remainder carry-over, saturating
//            pending-SKP counter and sticky overflow flag.
// Ports    : clk_i, rst_ni, link_up_i (low = flush), skp_disable_i,
//            bpc_i (bytes per cycle), skp_start_i (scheduler consumes one),
//            skp_pending_o, skp_overflow_o.
// Revision : 1.0 - initial release
// ============================================================================
module gen1_tx_os_scheduler_skp_interval_timer #(
    parameter int SKP_INTERVAL = 1180,
    parameter int MAX_PENDING  = 3
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    input  wire logic       link_up_i,
    input  wire logic       skp_disable_i,
    input  wire logic [2:0] bpc_i,
    input  wire logic       skp_start_i,
    output logic [2:0]      skp_pending_o,
    output logic            skp_overflow_o
);

    localparam logic [12:0] c_INTERVAL = 13'(SKP_INTERVAL);
    localparam logic [2:0]  c_MAX      = 3'(MAX_PENDING);

    logic [12:0] r_timer;
    logic [2:0]  r_pending;
    logic        r_overflow;

    logic        w_enable;
    logic [12:0] w_sum;
    logic        w_event;

    assign w_enable = link_up_i && !skp_disable_i;
    assign w_sum    = r_timer + 13'(bpc_i);
    assign w_event  = w_enable && (w_sum >= c_INTERVAL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timer    <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else if (!link_up_i) begin
            r_timer   <= '0;
            r_pending <= '0;
        end else begin
            if (w_enable) begin
                r_timer <= w_event ? (w_sum - c_INTERVAL) : w_sum;
            end
            // An event that coincides with a start nets to zero; no count is
            // lost then, so only an unmatched event at saturation overflows.
            if (w_event && !skp_start_i) begin
                if (r_pending == c_MAX) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pending <= r_pending + 3'd1;
                end
            end else if (!w_event && skp_start_i) begin
                r_pending <= r_pending - 3'd1;
            end
        end
    end

    assign skp_pending_o  = r_pending;
    assign skp_overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: rtl/gen1_tx_os_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gen1_tx_os_scheduler
// Purpose  : Per-lane arbiter feeding gen1_scramble: upstream packet beats,
//            periodic SKP ordered sets (inserted only at packet boundaries)
//            and logical idle, as a registered continuous stream.
// Ports    : clk_i, rst_ni (async, active low), pipe_width_i (8/16/32),
//            link_up_i, skp_disable_i, tx_if (slave beat handshake),
//            data_out_o/data_k_out_o/data_valid_o (to scrambler),
//            skp_sent_o, skp_pending_o, skp_overflow_o, tx_underrun_o.
// Revision : 1.0 - initial release
// ============================================================================
module gen1_tx_os_scheduler
    import gen1_tx_os_scheduler_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int MAX_PENDING  = 3
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic [5:0]       pipe_width_i,
    input  wire logic             link_up_i,
    input  wire logic             skp_disable_i,
    gen1_tx_os_scheduler_if.slave tx_if,
    output logic [31:0]           data_out_o,
    output logic [3:0]            data_k_out_o,
    output logic                  data_valid_o,
    output logic                  skp_sent_o,
    output logic [2:0]            skp_pending_o,
    output logic                  skp_overflow_o,
    output logic                  tx_underrun_o
);

    tx_sched_state_e r_state, w_state_nxt;
    logic [1:0]      r_beat_cnt, w_beat_cnt_nxt;
    logic [31:0]     r_data;
    logic [3:0]      r_k;
    logic            r_valid, r_skp_sent, r_underrun;

    logic [2:0]      w_bpc;
    logic [1:0]      w_last_idx;
    logic [2:0]      w_pending;
    logic            w_ready, w_accept, w_skp_start, w_skp_sent, w_underrun;
    tx_beat_t        w_beat, w_pkt_beat, w_os_beat;

    assign w_bpc      = bytes_per_cycle(pipe_width_i);
    assign w_pkt_beat = mask_beat(w_bpc, tx_if.tx_data, tx_if.tx_data_k);
    assign w_os_beat  = skp_os_beat(w_bpc, r_beat_cnt);

    // Final beat index of the 4-symbol set: 4/bpc - 1.
    always_comb begin
        case (w_bpc)
            3'd4:    w_last_idx = 2'd0;
            3'd2:    w_last_idx = 2'd1;
            default: w_last_idx = 2'd3;
        endcase
    end

    // A pending SKP in IDLE outranks a waiting beat, so ready drops then.
    assign w_ready      = link_up_i && ((r_state == PKT) || ((r_state == IDLE) && (w_pending == 3'd0)));
    assign w_accept     = tx_if.tx_valid && w_ready;
    assign tx_if.tx_ready = w_ready;

    gen1_tx_os_scheduler_skp_interval_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .MAX_PENDING  (MAX_PENDING)
    ) u_skp_timer (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .link_up_i      (link_up_i),
        .skp_disable_i  (skp_disable_i),
        .bpc_i          (w_bpc),
        .skp_start_i    (w_skp_start),
        .skp_pending_o  (w_pending),
        .skp_overflow_o (skp_overflow_o)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_beat.data    = {4{c_IDL_DATA}};
        w_beat.k       = 4'h0;
        w_skp_start    = 1'b0;
        w_skp_sent     = 1'b0;
        w_underrun     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pending != 3'd0) begin
                    w_state_nxt    = SKP_OS;
                    w_beat_cnt_nxt = 2'd0;
                    w_skp_start    = 1'b1;
                end else if (w_accept) begin
                    w_beat = w_pkt_beat;
                    if (!tx_if.tx_last) begin
                        w_state_nxt = PKT;
                    end
                end
            end
            PKT: begin
                if (w_accept) begin
                    w_beat = w_pkt_beat;
                    if (tx_if.tx_last) begin
                        if (w_pending != 3'd0) begin
                            w_state_nxt    = SKP_OS;
                            w_beat_cnt_nxt = 2'd0;
                            w_skp_start    = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end else begin
                    w_underrun = 1'b1;
                end
            end
            SKP_OS: begin
                w_beat = w_os_beat;
                if (r_beat_cnt == w_last_idx) begin
                    w_skp_sent = 1'b1;
                    if (w_pending != 3'd0) begin
                        w_beat_cnt_nxt = 2'd0;
                        w_skp_start    = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Link down flushes everything: partial packets and sets are dropped.
        if (!link_up_i) begin
            w_state_nxt    = IDLE;
            w_beat_cnt_nxt = 2'd0;
            w_beat         = '0;
            w_skp_start    = 1'b0;
            w_skp_sent     = 1'b0;
            w_underrun     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_beat_cnt <= 2'd0;
            r_data     <= '0;
            r_k        <= '0;
            r_valid    <= 1'b0;
            r_skp_sent <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_data     <= w_beat.data;
            r_k        <= w_beat.k;
            r_valid    <= link_up_i;
            r_skp_sent <= w_skp_sent;
            r_underrun <= w_underrun;
        end
    end

    assign data_out_o    = r_data;
    assign data_k_out_o  = r_k;
    assign data_valid_o  = r_valid;
    assign skp_sent_o    = r_skp_sent;
    assign skp_pending_o = w_pending;
    assign tx_underrun_o = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_gen1_tx_os_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen1_tx_os_scheduler
// Purpose  : Directed self-checking bench for gen1_tx_os_scheduler with
//            SKP_INTERVAL=16, MAX_PENDING=3 across 32b, 16b and 8b PIPE widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen1_tx_os_scheduler;

    logic        clk;
    logic        rst_n;
    logic [5:0]  pipe_width;
    logic        link_up;
    logic        skp_disable;
    logic [31:0] data_out;
    logic [3:0]  data_k_out;
    logic        data_valid;
    logic        skp_sent;
    logic [2:0]  skp_pending;
    logic        skp_overflow;
    logic        tx_underrun;

    int vectors;
    int miscompares;

    gen1_tx_os_scheduler_if u_if ();

    gen1_tx_os_scheduler #(
        .SKP_INTERVAL (16),
        .MAX_PENDING  (3)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pipe_width_i   (pipe_width),
        .link_up_i      (link_up),
        .skp_disable_i  (skp_disable),
        .tx_if          (u_if),
        .data_out_o     (data_out),
        .data_k_out_o   (data_k_out),
        .data_valid_o   (data_valid),
        .skp_sent_o     (skp_sent),
        .skp_pending_o  (skp_pending),
        .skp_overflow_o (skp_overflow),
        .tx_underrun_o  (tx_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] data, input logic [3:0] k, input logic last);
        u_if.tx_valid  = 1'b1;
        u_if.tx_data   = data;
        u_if.tx_data_k = k;
        u_if.tx_last   = last;
    endtask

    task automatic drive_none();
        u_if.tx_valid  = 1'b0;
        u_if.tx_last   = 1'b0;
        u_if.tx_data   = '0;
        u_if.tx_data_k = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        link_up     = 1'b0;
        skp_disable = 1'b0;
        pipe_width  = 6'd32;
        drive_none();
        step();
        step();

        // Reset values
        check_eq("rst_data",     data_out, 32'h0);
        check_eq("rst_k",        {28'h0, data_k_out}, 32'h0);
        check_eq("rst_valid",    {31'h0, data_valid}, 32'h0);
        check_eq("rst_sent",     {31'h0, skp_sent}, 32'h0);
        check_eq("rst_pending",  {29'h0, skp_pending}, 32'h0);
        check_eq("rst_overflow", {31'h0, skp_overflow}, 32'h0);
        check_eq("rst_underrun", {31'h0, tx_underrun}, 32'h0);
        check_eq("rst_ready",    {31'h0, u_if.tx_ready}, 32'h0);
        rst_n = 1'b1;
        step();

        // 32b, no traffic: event every 4 cycles, SKP 2 cycles after each event
        link_up = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            check_eq("b32_valid", {31'h0, data_valid}, 32'h1);
            if (n == 6 || n == 10) begin
                check_eq("b32_skp_data", data_out, 32'h1C1C1CBC);
                check_eq("b32_skp_k",    {28'h0, data_k_out}, 32'hF);
                check_eq("b32_skp_sent", {31'h0, skp_sent}, 32'h1);
            end else begin
                check_eq("b32_idle_data", data_out, 32'h0);
                check_eq("b32_idle_sent", {31'h0, skp_sent}, 32'h0);
            end
            if (n == 1) check_eq("b32_ready_idle", {31'h0, u_if.tx_ready}, 32'h1);
            if (n == 4) begin
                check_eq("b32_pending", {29'h0, skp_pending}, 32'h1);
                check_eq("b32_ready_pend", {31'h0, u_if.tx_ready}, 32'h0);
            end
        end
        link_up = 1'b0;
        step();
        check_eq("b32_down_valid", {31'h0, data_valid}, 32'h0);
        pipe_width = 6'd16;
        step();

        // 16b: 10-beat packet, timer fires mid-packet, SKP follows tx_last
        link_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_beat(32'hDEAD_A000 + i, 4'b1100, i == 9);
            #1;
            check_eq("b16_pkt_ready", {31'h0, u_if.tx_ready}, 32'h1);
            step();
            check_eq("b16_pkt_data", data_out, 32'h0000_A000 + i);
            check_eq("b16_pkt_k",    {28'h0, data_k_out}, 32'h0);
        end
        drive_none();
        check_eq("b16_ready_skp0", {31'h0, u_if.tx_ready}, 32'h0);
        step();
        check_eq("b16_skp0_data",  data_out, 32'h0000_1CBC);
        check_eq("b16_skp0_k",     {28'h0, data_k_out}, 32'h3);
        check_eq("b16_skp0_sent",  {31'h0, skp_sent}, 32'h0);
        check_eq("b16_ready_skp1", {31'h0, u_if.tx_ready}, 32'h0);
        step();
        check_eq("b16_skp1_data",  data_out, 32'h0000_1C1C);
        check_eq("b16_skp1_k",     {28'h0, data_k_out}, 32'h3);
        check_eq("b16_skp1_sent",  {31'h0, skp_sent}, 32'h1);
        check_eq("b16_ready_after", {31'h0, u_if.tx_ready}, 32'h1);

        // IDLE with pending=1 and a beat offered: SKP first, beat after
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq("b16_gap_data", data_out, 32'h0);
        end
        check_eq("b16_gap_pending", {29'h0, skp_pending}, 32'h1);
        drive_beat(32'hDEAD_BEEF, 4'b1100, 1'b1);
        #1;
        check_eq("race_ready", {31'h0, u_if.tx_ready}, 32'h0);
        step();
        check_eq("race_idle_data", data_out, 32'h0);
        check_eq("race_ready_skp", {31'h0, u_if.tx_ready}, 32'h0);
        step();
        check_eq("race_skp0", data_out, 32'h0000_1CBC);
        step();
        check_eq("race_skp1", data_out, 32'h0000_1C1C);
        check_eq("race_sent", {31'h0, skp_sent}, 32'h1);
        check_eq("race_ready_back", {31'h0, u_if.tx_ready}, 32'h1);
        step();
        check_eq("race_beat", data_out, 32'h0000_BEEF);
        drive_none();

        // Underrun: two empty cycles inside a packet
        drive_beat(32'hDEAD_C000, 4'b0000, 1'b0);
        step();
        check_eq("urun_first", data_out, 32'h0000_C000);
        drive_none();
        for (int n = 0; n < 2; n++) begin
            step();
            check_eq("urun_data",  data_out, 32'h0);
            check_eq("urun_pulse", {31'h0, tx_underrun}, 32'h1);
            check_eq("urun_valid", {31'h0, data_valid}, 32'h1);
        end
        drive_beat(32'hDEAD_C001, 4'b0000, 1'b1);
        step();
        check_eq("urun_last",    data_out, 32'h0000_C001);
        check_eq("urun_clear",   {31'h0, tx_underrun}, 32'h0);
        check_eq("urun_pending", {29'h0, skp_pending}, 32'h1);
        drive_none();
        link_up = 1'b0;
        step();
        check_eq("flush_valid",   {31'h0, data_valid}, 32'h0);
        check_eq("flush_pending", {29'h0, skp_pending}, 32'h0);
        check_eq("flush_data",    data_out, 32'h0);
        pipe_width = 6'd8;
        step();

        // 8b: 70-beat packet, pending saturates and overflows, 3 sets follow
        link_up = 1'b1;
        for (int i = 0; i < 70; i++) begin
            drive_beat(32'hFFFF_FF00 | i, 4'b1110, i == 69);
            step();
            check_eq("b8_pkt_data", data_out, 32'(i));
            check_eq("b8_pkt_k",    {28'h0, data_k_out}, 32'h0);
        end
        drive_none();
        check_eq("b8_overflow", {31'h0, skp_overflow}, 32'h1);
        check_eq("b8_pending",  {29'h0, skp_pending}, 32'h2);
        for (int j = 0; j < 12; j++) begin
            step();
            check_eq("b8_skp_data",  data_out, (j % 4 == 0) ? 32'h0000_00BC : 32'h0000_001C);
            check_eq("b8_skp_k",     {28'h0, data_k_out}, 32'h1);
            check_eq("b8_skp_sent",  {31'h0, skp_sent}, (j % 4 == 3) ? 32'h1 : 32'h0);
            check_eq("b8_skp_ready", {31'h0, u_if.tx_ready}, 32'h0);
        end

        // Link drop right after a COM: remaining SKP bytes never appear
        step();
        check_eq("drop_com", data_out, 32'h0000_00BC);
        link_up = 1'b0;
        step();
        check_eq("drop_valid",   {31'h0, data_valid}, 32'h0);
        check_eq("drop_pending", {29'h0, skp_pending}, 32'h0);
        check_eq("drop_data",    data_out, 32'h0);
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("drop_quiet", data_out, 32'h0);
            check_eq("drop_nosent", {31'h0, skp_sent}, 32'h0);
        end
        check_eq("drop_ovf_sticky", {31'h0, skp_overflow}, 32'h1);

        // skp_disable holds the timer; nothing gets scheduled
        link_up     = 1'b1;
        skp_disable = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            check_eq("dis_data", data_out, 32'h0);
        end
        check_eq("dis_pending", {29'h0, skp_pending}, 32'h0);
        check_eq("dis_valid",   {31'h0, data_valid}, 32'h1);
        skp_disable = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (data_out == 32'h0000_00BC) found = 1'b1;
        end
        check_eq("en_skp_seen", {31'h0, found}, 32'h1);

        // Asynchronous reset in the middle of an SKP set
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_data",     data_out, 32'h0);
        check_eq("arst_k",        {28'h0, data_k_out}, 32'h0);
        check_eq("arst_valid",    {31'h0, data_valid}, 32'h0);
        check_eq("arst_pending",  {29'h0, skp_pending}, 32'h0);
        check_eq("arst_overflow", {31'h0, skp_overflow}, 32'h0);
        step();
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
